// File: rtl/a2d_round_robin_seq_pkg.sv
// Shared types and constants for the round-robin A2D sequencer.
//   state_t       : sequencer FSM states
//   IDX_*         : round slot index of each analog channel
//   CHNL_*_DFLT   : default A2D channel codes for each slot
package a2d_round_robin_seq_pkg;

    localparam int unsigned IDX_W    = 2;
    localparam int unsigned CHNL_W   = 3;
    localparam int unsigned RES_W    = 12;
    localparam int unsigned NUM_CHNL = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Fixed conversion order within a round
    localparam logic [IDX_W-1:0] IDX_LFT   = 2'd0;
    localparam logic [IDX_W-1:0] IDX_RGHT  = 2'd1;
    localparam logic [IDX_W-1:0] IDX_STEER = 2'd2;
    localparam logic [IDX_W-1:0] IDX_BATT  = 2'd3;

    localparam logic [CHNL_W-1:0] CHNL_LFT_DFLT   = 3'b000;
    localparam logic [CHNL_W-1:0] CHNL_RGHT_DFLT  = 3'b100;
    localparam logic [CHNL_W-1:0] CHNL_STEER_DFLT = 3'b101;
    localparam logic [CHNL_W-1:0] CHNL_BATT_DFLT  = 3'b110;

endpackage

// File: rtl/a2d_period_tmr.sv
// Free-running round-trigger counter; tick_c is high for the one clock in
// which the counter holds all-ones, i.e. once every 2^PERIOD_BITS clocks.
//   clk    : system clock
//   rst    : synchronous, active-high reset (counter to 0)
//   tick_c : round trigger (decoded from the counter register)
module a2d_period_tmr #(
    parameter int unsigned PERIOD_BITS = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick_c
);

    logic [PERIOD_BITS-1:0] cnt;

    // Wraps all-ones -> 0 naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_BITS'(1);
        end
    end

    assign tick_c = &cnt;

endmodule

// File: rtl/a2d_round_robin_seq.sv
// Round-robin scheduler for the shared SPI A2D converter. Every period tick
// (while enabled and idle) it converts left load cell, right load cell,
// steering pot and battery in that order, holding each 12-bit result.
//   clk, rst         : clock, synchronous active-high reset
//   en               : allow new rounds to start
//   cnv_cmplt, res   : A2D done pulse and its result
//   strt_cnv, chnl   : A2D start pulse and channel select
//   lft_ld, rght_ld, steer_pot, batt : latest samples
//   vld              : pulse after a round that finished without timeout
//   a2d_err          : sticky conversion-timeout flag
module a2d_round_robin_seq
    import a2d_round_robin_seq_pkg::*;
#(
    parameter logic [2:0]  CHNL_LFT    = CHNL_LFT_DFLT,
    parameter logic [2:0]  CHNL_RGHT   = CHNL_RGHT_DFLT,
    parameter logic [2:0]  CHNL_STEER  = CHNL_STEER_DFLT,
    parameter logic [2:0]  CHNL_BATT   = CHNL_BATT_DFLT,
    parameter int unsigned PERIOD_BITS = 10,
    parameter int unsigned TMO_CYC     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cnv_cmplt,
    input  logic [RES_W-1:0]  res,
    output logic              strt_cnv,
    output logic [CHNL_W-1:0] chnl,
    output logic [RES_W-1:0]  lft_ld,
    output logic [RES_W-1:0]  rght_ld,
    output logic [RES_W-1:0]  steer_pot,
    output logic [RES_W-1:0]  batt,
    output logic              vld,
    output logic              a2d_err
);

    localparam int unsigned TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               round_err_q, round_err_d;
    logic               strt_cnv_d;
    logic [CHNL_W-1:0]  chnl_d;
    logic               vld_d;
    logic               a2d_err_d;
    logic [RES_W-1:0]   lft_d, rght_d, steer_d, batt_d;
    logic               adv_c;
    logic               tick_c;

    // Slot index to A2D channel code
    function automatic logic [CHNL_W-1:0] chnl_code(input logic [IDX_W-1:0] i);
        logic [CHNL_W-1:0] code;
        case (i)
            IDX_LFT:   code = CHNL_LFT;
            IDX_RGHT:  code = CHNL_RGHT;
            IDX_STEER: code = CHNL_STEER;
            default:   code = CHNL_BATT;
        endcase
        return code;
    endfunction

    a2d_period_tmr #(
        .PERIOD_BITS (PERIOD_BITS)
    ) u_period_tmr (
        .clk    (clk),
        .rst    (rst),
        .tick_c (tick_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        round_err_d = round_err_q;
        a2d_err_d   = a2d_err;
        lft_d       = lft_ld;
        rght_d      = rght_ld;
        steer_d     = steer_pot;
        batt_d      = batt;
        adv_c       = 1'b0;

        case (state_q)
            IDLE: begin
                // Ticks seen outside IDLE are simply lost
                if (tick_c && en) begin
                    state_d     = CONV;
                    idx_d       = IDX_LFT;
                    round_err_d = 1'b0;
                end
            end
            CONV: begin
                // A completion arriving with the start pulse is not ours
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion on the timeout clock still counts as success
                if (cnv_cmplt) begin
                    adv_c = 1'b1;
                    case (idx_q)
                        IDX_LFT:   lft_d   = res;
                        IDX_RGHT:  rght_d  = res;
                        IDX_STEER: steer_d = res;
                        default:   batt_d  = res;
                    endcase
                end else if (tmo_q == TMO_W'(TMO_CYC)) begin
                    adv_c       = 1'b1;
                    a2d_err_d   = 1'b1;
                    round_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (adv_c) begin
                    if (idx_q != IDX_BATT) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = CONV;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Register start/channel so they are high exactly while in CONV
        strt_cnv_d = (state_d == CONV);
        chnl_d     = (state_d == CONV) ? chnl_code(idx_d) : chnl;
        vld_d      = (state_q == DONE) && !round_err_q;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            round_err_q <= 1'b0;
            strt_cnv    <= 1'b0;
            chnl        <= CHNL_LFT;
            vld         <= 1'b0;
            a2d_err     <= 1'b0;
            lft_ld      <= '0;
            rght_ld     <= '0;
            steer_pot   <= '0;
            batt        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            round_err_q <= round_err_d;
            strt_cnv    <= strt_cnv_d;
            chnl        <= chnl_d;
            vld         <= vld_d;
            a2d_err     <= a2d_err_d;
            lft_ld      <= lft_d;
            rght_ld     <= rght_d;
            steer_pot   <= steer_d;
            batt        <= batt_d;
        end
    end

endmodule

// File: tb/tb_a2d_round_robin_seq.sv
// Self-checking bench for a2d_round_robin_seq with a behavioural A2D model
// and a channel-order scoreboard.
module tb_a2d_round_robin_seq;

    localparam logic [2:0] CH_L = 3'b000;
    localparam logic [2:0] CH_R = 3'b100;
    localparam logic [2:0] CH_S = 3'b101;
    localparam logic [2:0] CH_B = 3'b110;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnl;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        vld;
    logic        a2d_err;

    a2d_round_robin_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .strt_cnv  (strt_cnv),
        .chnl      (chnl),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .vld       (vld),
        .a2d_err   (a2d_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard / counters
    int          n_pass, n_total;
    logic [2:0]  exp_q[$];
    logic [2:0]  obs_chnl[128];
    int          sb_rd;

    // Monitor state
    int          cyc, n_strt, vld_cnt, last_tick, last_vld, err_rise, ovl_cnt;
    int          strt_cyc[8];
    logic        err_q;

    // A2D model state and configuration
    logic [9:0]  pcnt;
    int          adc_delay;
    logic [8:0]  adc_tag;
    bit          adc_skip_en, adc_early_en, adc_ovr_en;
    logic [2:0]  adc_skip_ch, adc_early_ch, adc_ovr_ch;
    logic [11:0] adc_ovr_val;
    bit          adc_pending, adc_ovl;
    int          adc_cnt;
    logic [2:0]  adc_ch;

    // A2D model: answers L clks after strt_cnv with {tag, chnl}; mirrors period counter
    initial begin
        cnv_cmplt   = 1'b0;
        res         = 12'h000;
        adc_pending = 1'b0;
        adc_ovl     = 1'b0;
        adc_cnt     = 0;
        adc_ch      = 3'b000;
        pcnt        = 10'd0;
        forever begin
            @(posedge clk);
            #1;
            pcnt      = rst ? 10'd0 : pcnt + 10'd1;
            cnv_cmplt = 1'b0;
            res       = 12'h000;
            adc_ovl   = 1'b0;
            if (adc_pending) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    adc_pending = 1'b0;
                    cnv_cmplt   = 1'b1;
                    res = (adc_ovr_en && adc_ch == adc_ovr_ch) ? adc_ovr_val : {adc_tag, adc_ch};
                end
            end
            if (strt_cnv === 1'b1) begin
                adc_ovl = adc_pending;
                if (!(adc_skip_en && chnl == adc_skip_ch)) begin
                    adc_pending = 1'b1;
                    adc_cnt     = adc_delay;
                    adc_ch      = chnl;
                end
                if (adc_early_en && chnl == adc_early_ch) begin
                    cnv_cmplt = 1'b1;
                    res       = 12'h123;
                end
            end
        end
    end

    // Monitor: records ticks, vld pulses, error rise and every strt_cnv
    initial begin
        cyc = 0; n_strt = 0; vld_cnt = 0; last_tick = 0; last_vld = 0;
        err_rise = 0; ovl_cnt = 0; err_q = 1'b0;
        for (int i = 0; i < 8; i++) strt_cyc[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pcnt == 10'h3FF) last_tick = cyc;
            if (vld === 1'b1) begin
                vld_cnt++;
                last_vld = cyc;
            end
            if (a2d_err === 1'b1 && !err_q) err_rise = cyc;
            err_q = (a2d_err === 1'b1);
            if (strt_cnv === 1'b1) begin
                if (n_strt < 128) obs_chnl[n_strt] = chnl;
                strt_cyc[chnl] = cyc;
                if (adc_ovl) ovl_cnt++;
                n_strt++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strts(input int target, input int bound, input string tag);
        int n = 0;
        while (n_strt < target && n < bound) begin
            step();
            n++;
        end
        if (n_strt < target) begin
            n_total++;
            $display("FAIL %s strt wait: saw %0d strt_cnv, required %0d", tag, n_strt, target);
        end
    endtask

    task automatic wait_vld(input int prev, input int bound, input string tag);
        int n = 0;
        while (vld_cnt <= prev && n < bound) begin
            step();
            n++;
        end
        if (vld_cnt <= prev) begin
            n_total++;
            $display("FAIL %s vld wait: no vld within %0d clks", tag, bound);
        end
    endtask

    task automatic push_round();
        exp_q.push_back(CH_L);
        exp_q.push_back(CH_R);
        exp_q.push_back(CH_S);
        exp_q.push_back(CH_B);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) step();
        n_total++; if (strt_cnv !== 1'b0) $display("FAIL reset strt_cnv: got %b want 0", strt_cnv); else n_pass++;
        n_total++; if (chnl !== CH_L) $display("FAIL reset chnl: got %b want %b", chnl, CH_L); else n_pass++;
        n_total++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0)
            $display("FAIL reset regs: got %h want 0", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
        n_total++; if ({vld, a2d_err} !== 2'b00) $display("FAIL reset flags: got %b want 00", {vld, a2d_err}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic_round();
        int vc;
        logic [2:0] e;
        adc_delay = 3;
        adc_tag   = 9'h000;
        push_round();
        vc = vld_cnt;
        en = 1'b1;
        wait_strts(sb_rd + 4, 2500, "basic");
        wait_vld(vc, 100, "basic");
        en = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (sb_rd >= n_strt) $display("FAIL basic chnl: missing strt_cnv, want %b", e);
            else begin
                if (obs_chnl[sb_rd] !== e) $display("FAIL basic chnl: got %b want %b", obs_chnl[sb_rd], e); else n_pass++;
                sb_rd++;
            end
        end
        n_total++; if (strt_cyc[CH_L] - last_tick != 1) $display("FAIL basic strt latency: got %0d want 1", strt_cyc[CH_L] - last_tick); else n_pass++;
        n_total++; if (last_vld - last_tick != 18) $display("FAIL basic vld latency: got %0d want 18", last_vld - last_tick); else n_pass++;
        n_total++; if (lft_ld !== 12'h000) $display("FAIL basic lft_ld: got %h want 000", lft_ld); else n_pass++;
        n_total++; if (rght_ld !== 12'h004) $display("FAIL basic rght_ld: got %h want 004", rght_ld); else n_pass++;
        n_total++; if (steer_pot !== 12'h005) $display("FAIL basic steer_pot: got %h want 005", steer_pot); else n_pass++;
        n_total++; if (batt !== 12'h006) $display("FAIL basic batt: got %h want 006", batt); else n_pass++;
        n_total++; if (a2d_err !== 1'b0) $display("FAIL basic a2d_err: got %b want 0", a2d_err); else n_pass++;
        step();
        n_total++; if (vld !== 1'b0) $display("FAIL basic vld width: got %b want 0", vld); else n_pass++;
    endtask

    task automatic test_timeout();
        int vc;
        logic [2:0] e;
        adc_delay   = 3;
        adc_tag     = 9'h01A;
        adc_skip_en = 1'b1;
        adc_skip_ch = CH_S;
        push_round();
        vc = vld_cnt;
        en = 1'b1;
        wait_strts(sb_rd + 4, 2500, "tmo");
        repeat (10) step();
        n_total++; if (vld_cnt != vc) $display("FAIL tmo vld: got %0d pulses want 0", vld_cnt - vc); else n_pass++;
        n_total++; if (a2d_err !== 1'b1) $display("FAIL tmo a2d_err: got %b want 1", a2d_err); else n_pass++;
        n_total++; if (err_rise - strt_cyc[CH_S] != 257) $display("FAIL tmo err timing: got %0d want 257", err_rise - strt_cyc[CH_S]); else n_pass++;
        n_total++; if (steer_pot !== 12'h005) $display("FAIL tmo steer_pot: got %h want 005", steer_pot); else n_pass++;
        n_total++; if (batt !== 12'h0D6) $display("FAIL tmo batt: got %h want 0d6", batt); else n_pass++;
        n_total++; if (rght_ld !== 12'h0D4) $display("FAIL tmo rght_ld: got %h want 0d4", rght_ld); else n_pass++;
        adc_skip_en = 1'b0;
        adc_tag     = 9'h002;
        push_round();
        wait_strts(sb_rd + 8, 2500, "tmo next");
        wait_vld(vc, 40, "tmo next");
        en = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (sb_rd >= n_strt) $display("FAIL tmo chnl: missing strt_cnv, want %b", e);
            else begin
                if (obs_chnl[sb_rd] !== e) $display("FAIL tmo chnl: got %b want %b", obs_chnl[sb_rd], e); else n_pass++;
                sb_rd++;
            end
        end
        n_total++; if (a2d_err !== 1'b1) $display("FAIL tmo sticky: got %b want 1", a2d_err); else n_pass++;
        n_total++; if (steer_pot !== 12'h015) $display("FAIL tmo next steer_pot: got %h want 015", steer_pot); else n_pass++;
    endtask

    task automatic test_reset_mid_round();
        int vc, r_cyc;
        logic [2:0] e;
        adc_delay   = 3;
        adc_tag     = 9'h003;
        adc_ovr_en  = 1'b1;
        adc_ovr_ch  = CH_R;
        adc_ovr_val = 12'hABC;
        exp_q.push_back(CH_L);
        exp_q.push_back(CH_R);
        en = 1'b1;
        wait_strts(sb_rd + 2, 2500, "rst mid");
        r_cyc = cyc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++; if (strt_cnv !== 1'b0) $display("FAIL rst mid strt_cnv: got %b want 0", strt_cnv); else n_pass++;
        n_total++; if (chnl !== CH_L) $display("FAIL rst mid chnl: got %b want %b", chnl, CH_L); else n_pass++;
        n_total++; if (lft_ld !== 12'h000) $display("FAIL rst mid lft_ld: got %h want 000", lft_ld); else n_pass++;
        n_total++; if (a2d_err !== 1'b0) $display("FAIL rst mid a2d_err: got %b want 0", a2d_err); else n_pass++;
        repeat (4) step();
        n_total++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0)
            $display("FAIL rst mid late cmplt: got %h want 0", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
        adc_ovr_en = 1'b0;
        push_round();
        vc = vld_cnt;
        wait_strts(sb_rd + 6, 1500, "rst restart");
        wait_vld(vc, 40, "rst restart");
        en = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (sb_rd >= n_strt) $display("FAIL rst mid chnl: missing strt_cnv, want %b", e);
            else begin
                if (obs_chnl[sb_rd] !== e) $display("FAIL rst mid chnl: got %b want %b", obs_chnl[sb_rd], e); else n_pass++;
                sb_rd++;
            end
        end
        n_total++; if (last_tick - r_cyc != 1024) $display("FAIL rst restart tick: got %0d want 1024", last_tick - r_cyc); else n_pass++;
        n_total++; if (strt_cyc[CH_L] - last_tick != 1) $display("FAIL rst restart strt: got %0d want 1", strt_cyc[CH_L] - last_tick); else n_pass++;
        n_total++; if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h018, 12'h01C, 12'h01D, 12'h01E})
            $display("FAIL rst restart regs: got %h want 01801c01d01e", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
    endtask

    task automatic test_en_drop();
        int vc, n0;
        logic [2:0] e;
        adc_delay = 3;
        adc_tag   = 9'h004;
        push_round();
        vc = vld_cnt;
        en = 1'b1;
        wait_strts(sb_rd + 1, 2500, "en drop");
        en = 1'b0;
        wait_strts(sb_rd + 4, 40, "en drop");
        wait_vld(vc, 40, "en drop");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (sb_rd >= n_strt) $display("FAIL en drop chnl: missing strt_cnv, want %b", e);
            else begin
                if (obs_chnl[sb_rd] !== e) $display("FAIL en drop chnl: got %b want %b", obs_chnl[sb_rd], e); else n_pass++;
                sb_rd++;
            end
        end
        n_total++; if (batt !== 12'h026) $display("FAIL en drop batt: got %h want 026", batt); else n_pass++;
        n0 = n_strt;
        repeat (2100) step();
        n_total++; if (n_strt != n0) $display("FAIL en drop idle: got %0d strt_cnv want 0", n_strt - n0); else n_pass++;
    endtask

    task automatic test_cmplt_in_conv();
        int vc;
        logic [2:0] e;
        adc_delay    = 2;
        adc_tag      = 9'h005;
        adc_early_en = 1'b1;
        adc_early_ch = CH_L;
        adc_ovr_en   = 1'b1;
        adc_ovr_ch   = CH_L;
        adc_ovr_val  = 12'h7FF;
        push_round();
        vc = vld_cnt;
        en = 1'b1;
        wait_strts(sb_rd + 4, 2500, "early");
        wait_vld(vc, 40, "early");
        en = 1'b0;
        adc_early_en = 1'b0;
        adc_ovr_en   = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (sb_rd >= n_strt) $display("FAIL early chnl: missing strt_cnv, want %b", e);
            else begin
                if (obs_chnl[sb_rd] !== e) $display("FAIL early chnl: got %b want %b", obs_chnl[sb_rd], e); else n_pass++;
                sb_rd++;
            end
        end
        n_total++; if (lft_ld !== 12'h7FF) $display("FAIL early lft_ld: got %h want 7ff", lft_ld); else n_pass++;
        n_total++; if (rght_ld !== 12'h02C) $display("FAIL early rght_ld: got %h want 02c", rght_ld); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int vc, s1, t1;
        logic [2:0] e;
        adc_delay = 256;
        adc_tag   = 9'h00F;
        push_round();
        push_round();
        vc = vld_cnt;
        en = 1'b1;
        wait_strts(sb_rd + 1, 2500, "b2b");
        s1 = strt_cyc[CH_L];
        t1 = last_tick;
        n_total++; if (s1 - t1 != 1) $display("FAIL b2b strt latency: got %0d want 1", s1 - t1); else n_pass++;
        wait_vld(vc, 1100, "b2b");
        n_total++; if (last_vld - t1 != 1030) $display("FAIL b2b vld latency: got %0d want 1030", last_vld - t1); else n_pass++;
        n_total++; if (a2d_err !== 1'b0) $display("FAIL b2b edge capture err: got %b want 0", a2d_err); else n_pass++;
        n_total++; if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h078, 12'h07C, 12'h07D, 12'h07E})
            $display("FAIL b2b regs: got %h want 07807c07d07e", {lft_ld, rght_ld, steer_pot, batt}); else n_pass++;
        wait_strts(sb_rd + 5, 1100, "b2b second");
        n_total++; if (strt_cyc[CH_L] - s1 != 2048) $display("FAIL b2b dropped tick: got %0d want 2048", strt_cyc[CH_L] - s1); else n_pass++;
        en = 1'b0;
        wait_vld(vc + 1, 1100, "b2b second");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (sb_rd >= n_strt) $display("FAIL b2b chnl: missing strt_cnv, want %b", e);
            else begin
                if (obs_chnl[sb_rd] !== e) $display("FAIL b2b chnl: got %b want %b", obs_chnl[sb_rd], e); else n_pass++;
                sb_rd++;
            end
        end
        n_total++; if (ovl_cnt != 0) $display("FAIL b2b overlap: got %0d overlapping strt_cnv want 0", ovl_cnt); else n_pass++;
        n_total++; if (n_strt != sb_rd) $display("FAIL b2b extra strt: got %0d want %0d", n_strt, sb_rd); else n_pass++;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        sb_rd        = 0;
        rst          = 1'b1;
        en           = 1'b0;
        adc_delay    = 3;
        adc_tag      = 9'h000;
        adc_skip_en  = 1'b0;
        adc_skip_ch  = 3'b000;
        adc_early_en = 1'b0;
        adc_early_ch = 3'b000;
        adc_ovr_en   = 1'b0;
        adc_ovr_ch   = 3'b000;
        adc_ovr_val  = 12'h000;
        test_reset();
        test_basic_round();
        test_timeout();
        test_reset_mid_round();
        test_en_drop();
        test_cmplt_in_conv();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
